// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and FSM encoding for the instruction fetch unit
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  // Queue entry layout is {pc, instr}; the instruction occupies the low bits.
  localparam int unsigned ENTRY_INSTR_LSB = 0;
  localparam int unsigned ENTRY_PC_LSB    = INSTR_W;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO holding fetched {pc, instr} entries
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // Flush voids any same-cycle transfer; a push into a full queue needs a pop alongside it.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  // When empty, keep presenting the most recently popped entry.
  assign data_o = empty_o ? last_q : mem_q[rd_ptr_q];

  // Pointer, occupancy and last-popped bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Entry storage; contents are only meaningful below count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, fetch/redirect arbitration and halt FSM; optional FETCH_MISALIGN_TRAP_EN
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        FQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               fetch_fault
);

  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  fetch_state_e       state_q, state_d;
  logic               fault_q, fault_d;
  logic [ADDR_W-1:0]  redir_target;
  logic               redir_misaligned;
  logic               q_full, q_empty;
  logic               push, pop;
  logic [ENTRY_W-1:0] head;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_target     = redirect_pc;
  assign redir_misaligned = |redirect_pc[1:0];
`else
  assign redir_target     = redirect_pc & ~ADDR_W'(3);
  assign redir_misaligned = 1'b0;
`endif

  assign pop  = ~q_empty & out_ready;
  assign push = fetch_en & ~redirect_valid & (state_q == ST_RUN) & (~q_full | pop);

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  ({pc_q, imem_rdata}),
    .data_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign imem_addr   = pc_q;
  assign out_valid   = ~q_empty;
  assign out_pc      = head[ENTRY_PC_LSB +: ADDR_W];
  assign out_instr   = head[ENTRY_INSTR_LSB +: INSTR_W];
  assign fetch_fault = fault_q;

  // Next PC, FSM state and sticky fault; redirect outranks sequential fetch.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      if (redir_misaligned) begin
        state_d = ST_HALT;
        fault_d = 1'b1;
      end else begin
        state_d = ST_RUN;
        fault_d = 1'b0;
        pc_d    = redir_target;
      end
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(PC_INC);
    end
  end

  // State registers for PC, FSM and fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit against a queue-level model
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned FQ_DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_rdata, out_pc, out_instr;
  logic        out_valid, fetch_fault;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mq[$];
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic [63:0] m_last;
  bit          m_halt;
  bit          m_fault;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_fault    (fetch_fault)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted head entry must match the next entry the model delivered.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", {out_pc, out_instr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("transfer", {out_pc, out_instr}, exp_q.pop_front());
      end
    end
  end

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_pc    = RESET_PC;
    m_last  = '0;
    m_halt  = 0;
    m_fault = 0;
  endtask

  // Model of one clock edge using the inputs currently applied.
  task automatic model_step();
    int unsigned sz = mq.size();
    bit popping = (sz != 0) && out_ready;
    if (redirect_valid) begin
      mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        m_halt  = 1;
        m_fault = 1;
      end else begin
        m_halt  = 0;
        m_fault = 0;
        m_pc    = redirect_pc;
      end
`else
      m_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
    end else begin
      if (popping) begin
        m_last = mq.pop_front();
        exp_q.push_back(m_last);
      end
      if (fetch_en && !m_halt && (sz < FQ_DEPTH || popping)) begin
        mq.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_state(input string nm);
    logic [63:0] cur;
    cur = (mq.size() != 0) ? mq[0] : m_last;
    chk({nm, ":imem_addr"}, imem_addr, m_pc);
    chk({nm, ":out_valid"}, out_valid, mq.size() != 0);
    chk({nm, ":head"}, {out_pc, out_instr}, cur);
    chk({nm, ":fault"}, fetch_fault, m_fault);
  endtask

  task automatic step(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc);
    fetch_en       = fe;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    model_step();
    @(posedge clk);
    #2;
    check_state("cyc");
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    model_reset();
    #1;
    check_state("reset");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    check_state("reset_rel");
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] rpc;
    model_reset();
    #2;
    do_reset();

    // Stall decode from reset: queue fills with pc 0 and 4, pc parks at 8.
    repeat (5) step(1, 0, 0, '0);
    chk("fill_pc_parked", imem_addr, 32'h8);
    chk("fill_head", {out_pc, out_instr}, {32'h0, 32'h1000_0000});
    repeat (6) step(1, 1, 0, '0);

    // Redirect while full flushes; target 0x14 delivered after.
    repeat (3) step(1, 0, 0, '0);
    step(1, 0, 1, 32'h14);
    chk("redir_flush_valid", out_valid, 1'b0);
    step(1, 1, 0, '0);
    chk("redir_target", {out_pc, out_instr}, {32'h14, 32'h1000_0005});
    repeat (2) step(1, 1, 0, '0);

    // Redirect with a same-cycle pop on a full queue.
    repeat (3) step(1, 0, 0, '0);
    step(1, 1, 1, 32'h40);
    chk("redir_pop_valid", out_valid, 1'b0);
    repeat (3) step(1, 1, 0, '0);

    // Global stall drains the queue and freezes the address.
    held = imem_addr;
    repeat (3) step(0, 1, 0, '0);
    chk("stall_addr", imem_addr, held);
    chk("stall_drained", out_valid, 1'b0);

    // Misaligned redirect.
    step(1, 0, 1, 32'h22);
    step(1, 0, 0, '0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign_fault", fetch_fault, 1'b1);
    chk("misalign_nofetch", out_valid, 1'b0);
    step(1, 0, 1, 32'h20);
    step(1, 0, 0, '0);
    chk("misalign_clear", fetch_fault, 1'b0);
`endif
    chk("misalign_pc", out_pc, 32'h20);

    // PC wrap at the top of the address space.
    step(1, 1, 1, 32'hFFFF_FFF8);
    repeat (4) step(1, 1, 0, '0);

    // Reset in the middle of traffic.
    repeat (2) step(1, 0, 0, '0);
    do_reset();

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        rpc = 32'($urandom_range(0, 255)) << 2;
        if ($urandom_range(0, 9) == 0) rpc = rpc | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 19) == 0) rpc = 32'hFFFF_FFF4;
        step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
             $urandom_range(0, 19) == 0, rpc);
      end
    end

    // Final drain; every delivered entry must have been seen by the monitor.
    repeat (4) step(0, 1, 0, '0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
